// File: rtl/dac_spi_sched.sv
// dac_spi_sched: two-channel DAC write scheduler in front of an SPI master.
//
// Accepts held write requests from channels A and B, arbitrates round-robin,
// builds the 16-bit DAC command word and hands it to the SPI master. A minimum
// idle gap is enforced after every completed transfer to satisfy the DAC's
// CS-high time. Optionally pulses ldac_n once both channels have been written.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   req_a/b    channel write request, held until the matching ack
//   data_a/b   10-bit DAC code for the channel
//   ack_a/b    one-cycle pulse when the channel's request is accepted
//   gain_1x    gain select captured at grant (1 = 1x, 0 = 2x)
//   out_en     output enable captured at grant (0 = shutdown)
//   spi_start  one-cycle start strobe to the SPI master
//   spi_data   command word, stable from grant until spi_done
//   spi_done   one-cycle completion strobe from the SPI master
//   ldac_n     DAC latch strobe, active low
//   busy       high whenever the scheduler is not idle
module dac_spi_sched #(
    parameter int unsigned GAP_CYCLES  = 5,
    parameter bit          SYNC_UPDATE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [9:0]  data_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [9:0]  data_b,
    output logic        ack_b,
    input  logic        gain_1x,
    input  logic        out_en,
    output logic        spi_start,
    output logic [15:0] spi_data,
    input  logic        spi_done,
    output logic        ldac_n,
    output logic        busy
);

    localparam int unsigned CntW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

    localparam logic [1:0] StGap   = 2'd0;
    localparam logic [1:0] StIdle  = 2'd1;
    localparam logic [1:0] StStart = 2'd2;
    localparam logic [1:0] StWait  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] gap_cnt_q, gap_cnt_d;
    logic            last_b_q, last_b_d;   // most recent grant went to B
    logic            grant_b_q, grant_b_d; // channel owning the current transfer
    logic [15:0]     spi_data_q, spi_data_d;
    logic            wr_a_q, wr_a_d;
    logic            wr_b_q, wr_b_d;
    logic            sync_pulse;

    // Latch strobe fires on a GAP cycle once both channels hold fresh codes.
    assign sync_pulse = (state_q == StGap) && wr_a_q && wr_b_q;

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        last_b_d   = last_b_q;
        grant_b_d  = grant_b_q;
        spi_data_d = spi_data_q;
        wr_a_d     = wr_a_q;
        wr_b_d     = wr_b_q;
        case (state_q)
            StGap: begin
                if (sync_pulse) begin
                    wr_a_d = 1'b0;
                    wr_b_d = 1'b0;
                end
                if (gap_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - CntW'(1);
                end
            end
            StIdle: begin
                if (req_a || req_b) begin
                    // On a tie, B wins only if A was served last.
                    grant_b_d  = req_b && (!req_a || !last_b_q);
                    last_b_d   = grant_b_d;
                    spi_data_d = grant_b_d ? {1'b1, 1'b0, gain_1x, out_en, data_b, 2'b00}
                                           : {1'b0, 1'b0, gain_1x, out_en, data_a, 2'b00};
                    state_d    = StStart;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (spi_done) begin
                    state_d   = StGap;
                    gap_cnt_d = GapLoad;
                    if (grant_b_q) begin
                        wr_b_d = 1'b1;
                    end else begin
                        wr_a_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = StGap;
                gap_cnt_d = GapLoad;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StGap;
            gap_cnt_q  <= GapLoad;
            last_b_q   <= 1'b1;
            grant_b_q  <= 1'b0;
            spi_data_q <= 16'h0000;
            wr_a_q     <= 1'b0;
            wr_b_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            last_b_q   <= last_b_d;
            grant_b_q  <= grant_b_d;
            spi_data_q <= spi_data_d;
            wr_a_q     <= wr_a_d;
            wr_b_q     <= wr_b_d;
        end
    end

    assign spi_start = (state_q == StStart);
    assign ack_a     = spi_start && !grant_b_q;
    assign ack_b     = spi_start && grant_b_q;
    assign spi_data  = spi_data_q;
    assign busy      = (state_q != StIdle);
    // Without synchronous update the DAC latches on CS rising edge.
    assign ldac_n    = SYNC_UPDATE ? !sync_pulse : 1'b0;

endmodule

// File: tb/tb_dac_spi_sched.sv
// Testbench for dac_spi_sched: two instances (SYNC_UPDATE 0 and 1) share all
// inputs; expected grants are queued when requests are driven and compared
// when spi_start appears.
module tb_dac_spi_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, gain_1x, out_en, spi_done;
    logic [9:0]  data_a, data_b;
    logic        ack_a, ack_b, spi_start, ldac_n, busy;
    logic [15:0] spi_data;
    logic        s_ack_a, s_ack_b, s_spi_start, s_ldac_n, s_busy;
    logic [15:0] s_spi_data;

    typedef struct {
        logic        ch;
        logic [15:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n;

    always #5 clk = ~clk;

    dac_spi_sched #(.GAP_CYCLES(5), .SYNC_UPDATE(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .gain_1x(gain_1x), .out_en(out_en),
        .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done),
        .ldac_n(ldac_n), .busy(busy)
    );

    dac_spi_sched #(.GAP_CYCLES(5), .SYNC_UPDATE(1'b1)) u_dut_sync (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(s_ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(s_ack_b),
        .gain_1x(gain_1x), .out_en(out_en),
        .spi_start(s_spi_start), .spi_data(s_spi_data), .spi_done(spi_done),
        .ldac_n(s_ldac_n), .busy(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic ch, input logic [15:0] word);
        exp_t e;
        e.ch   = ch;
        e.word = word;
        sb.push_back(e);
    endtask

    // Compare start strobe, acks and command word against the oldest queued grant.
    task automatic check_start(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(tag, {13'b0, spi_start, ack_a, ack_b, spi_data},
                  {13'b0, 1'b1, !e.ch, e.ch, e.word});
        end
    endtask

    task automatic wait_start(input int max, output int cnt);
        cnt = 0;
        while (!spi_start && cnt < max) begin
            step();
            cnt++;
        end
    endtask

    task automatic after_start();
        step();
        check("start_one_cycle", 32'({spi_start, ack_a, ack_b, busy}), 32'b0001);
    endtask

    task automatic do_done();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        check("done_to_gap", 32'({busy, spi_start}), 32'b10);
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b1; req_b = 1'b0; spi_done = 1'b0;
        data_a = 10'h2AB; data_b = 10'h000; gain_1x = 1'b0; out_en = 1'b1;
        push(1'b0, 16'h1AAC);

        // Reset values
        step();
        check("rst_ctrl", 32'({busy, spi_start, ack_a, ack_b}), 32'b1000);
        check("rst_data", 32'(spi_data), 32'h0000);
        check("rst_ldac_nosync", 32'(ldac_n), 32'd0);
        check("rst_ldac_sync", 32'(s_ldac_n), 32'd1);
        step();
        rst = 1'b0;

        // Post-reset gap: GAP on cycles 0..4, IDLE on 5, START on 6
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) step();
            check("post_rst_gap", 32'({i != 5, i == 6}), 32'({busy, spi_start}));
        end
        check_start("wr_a_2ab");
        req_a = 1'b0;
        after_start();
        data_a = 10'h000; gain_1x = 1'b1;
        step();
        check("wait_hold", 32'(spi_data), 32'h1AAC);
        step();
        check("wait_hold2", 32'({busy, spi_data}), 32'h11AAC);
        do_done();
        check("ldac_a_only", 32'({s_ldac_n, ldac_n}), 32'b10);

        // Channel B full scale, then synchronous latch pulse
        req_b = 1'b1; data_b = 10'h3FF; gain_1x = 1'b1; out_en = 1'b1;
        push(1'b1, 16'hBFFC);
        wait_start(20, n);
        check("done_to_start_b", 32'(n), 32'd6);
        check_start("wr_b_3ff");
        req_b = 1'b0;
        after_start();
        do_done();
        check("ldac_pulse", 32'({s_ldac_n, ldac_n}), 32'b00);
        step();
        check("ldac_pulse_end", 32'(s_ldac_n), 32'd1);

        // A alone afterwards: no latch pulse
        req_a = 1'b1; data_a = 10'h155; gain_1x = 1'b1; out_en = 1'b0;
        push(1'b0, 16'h2554);
        wait_start(20, n);
        check("done_to_start_a", 32'(n), 32'd5);
        check_start("wr_a_155");
        req_a = 1'b0;
        after_start();
        do_done();
        // Request raised and withdrawn during GAP must be forgotten
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) req_b = 1'b1;
            if (i == 3) req_b = 1'b0;
            check("no_pulse_a_only", 32'({s_ldac_n, spi_start}), 32'b10);
        end
        check("idle_after_gap", 32'(busy), 32'd0);

        // Stray spi_done in IDLE
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_stray_done", 32'({busy, spi_start}), 32'b00);
            step();
        end

        // Contention: last grant was A, so B, A, B, A
        req_a = 1'b1; req_b = 1'b1; data_a = 10'h001; data_b = 10'h200;
        gain_1x = 1'b0; out_en = 1'b0;
        push(1'b1, 16'h8800); push(1'b0, 16'h0004);
        push(1'b1, 16'h8800); push(1'b0, 16'h0004);
        for (int k = 0; k < 4; k++) begin
            wait_start(20, n);
            check("cont_spacing", 32'(n), (k == 0) ? 32'd1 : 32'd6);
            check_start("cont_grant");
            after_start();
            do_done();
        end

        // Reset mid-WAIT abandons the transfer
        push(1'b1, 16'h8800);
        wait_start(20, n);
        check("cont_spacing5", 32'(n), 32'd6);
        check_start("cont_grant5");
        after_start();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midwait_rst", 32'({busy, spi_start, ack_a, ack_b, spi_data}), 32'h80000);
        check("midwait_rst_ldac", 32'(s_ldac_n), 32'd1);
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        check("gap_stray_done", 32'({busy, spi_start}), 32'b10);

        // After reset A wins the first tie, then B
        push(1'b0, 16'h0004); push(1'b1, 16'h8800);
        wait_start(20, n);
        check("rst_to_start", 32'(n), 32'd5);
        check_start("rst_tie_a");
        after_start();
        do_done();
        wait_start(20, n);
        check("rst_spacing", 32'(n), 32'd6);
        check_start("rst_tie_b");
        req_a = 1'b0; req_b = 1'b0;
        after_start();
        do_done();
        check("ldac_pulse_after_rst", 32'(s_ldac_n), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dac_spi_sched.md
DAC_SPI_SCHED -- requirements
Module: dac_spi_sched

Interface
REQ-001 Parameters SHALL be, one per line:
  GAP_CYCLES, 5, idle cycles enforced after each spi_done (DAC CS-high minimum; must be >= 1)
  SYNC_UPDATE, 0, 1 = drive ldac_n pulse when both channels are updated; 0 = ldac_n tied low
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  system clock; sole clock
  rst  in  1  synchronous, active-high reset
  req_a  in  1  channel A write request; held until ack_a
  data_a  in  10  channel A DAC code; stable while req_a high
  ack_a  out  1  one-cycle pulse; channel A request accepted
  req_b  in  1  channel B write request; held until ack_b
  data_b  in  10  channel B DAC code
  ack_b  out  1  one-cycle pulse; channel B request accepted
  gain_1x  in  1  DAC gain select, sampled at grant (1 = 1x, 0 = 2x)
  out_en  in  1  DAC output enable, sampled at grant (0 = shutdown)
  spi_start  out  1  one-cycle start strobe to the SPI master
  spi_data  out  16  command word to the SPI master
  spi_done  in  1  one-cycle transaction-complete strobe from the SPI master
  ldac_n  out  1  DAC latch strobe, active low
  busy  out  1  high whenever state is not IDLE
REQ-003 Clocking SHALL be one clock (clk); reset SHALL be synchronous and active-high (rst).

Function
REQ-004 FSM states SHALL be GAP, IDLE, START, WAIT; busy = (state != IDLE).
REQ-005 GAP SHALL last exactly GAP_CYCLES cycles, counting gap_cnt from GAP_CYCLES-1 down to 0, then go to IDLE.
REQ-006 IDLE with no request SHALL stay in IDLE; with any request, it SHALL grant one channel, register spi_data, and go to START.
REQ-007 Arbitration SHALL be round-robin: with both requests high, the grant goes to the channel not most recently granted; a single request is granted immediately.
REQ-008 spi_data SHALL be {ch, 1'b0, gain_1x, out_en, data, 2'b00}, with ch = 0 for A and 1 for B, and all fields sampled in the grant cycle.
REQ-009 START SHALL last one cycle with spi_start = 1 and the granted channel's ack = 1; the next state is WAIT.
REQ-010 WAIT SHALL hold spi_data stable until spi_done = 1, then go to GAP; there is no timeout.
REQ-011 Latency: request seen in IDLE at cycle T -> spi_start and ack at T+1; spi_done at cycle D -> earliest next spi_start at D+GAP_CYCLES+2.
REQ-012 spi_done outside WAIT SHALL be ignored; request changes outside IDLE SHALL be ignored.
REQ-013 A request dropped before its ack SHALL be treated as withdrawn; the block does not remember it.
REQ-014 ack_a and ack_b SHALL never be high in the same cycle; spi_start SHALL never be high outside START.
REQ-015 SYNC_UPDATE=1 behaviour:
  - Per-channel written flags set at that channel's spi_done.
  - On the first GAP cycle in which both flags are set, ldac_n = 0 for exactly one cycle and both flags clear.
  - ldac_n = 1 otherwise.
REQ-016 SYNC_UPDATE=0: ldac_n SHALL be constant 0 (DAC updates on CS rising edge).

Reset
REQ-017 While rst = 1 at a clk edge, the block SHALL enter GAP with gap_cnt = GAP_CYCLES-1, so the first spi_start comes no earlier than GAP_CYCLES+1 cycles after rst falls.
REQ-018 Reset values: spi_start=0, ack_a=0, ack_b=0, spi_data=16'h0000, busy=1, last-grant=B (A wins the first tie), written flags=0, ldac_n=1 if SYNC_UPDATE else 0.
REQ-019 Reset in any state, including mid-WAIT, SHALL abandon the transaction without emitting an ack or spi_start; the SPI master shares rst.

Verification
REQ-020 Post-reset gap: rst high 2 cycles then low, req_a=1 held, GAP_CYCLES=5 -> spi_start first high on the 7th cycle after rst falls; busy=1 through GAP.
REQ-021 Single write: IDLE, req_a=1, data_a=10'h2AB, gain_1x=0, out_en=1 -> next cycle spi_start=1, ack_a=1, spi_data=16'h1AAC, held until spi_done.
REQ-022 Channel B full-scale: req_b=1, data_b=10'h3FF, gain_1x=1, out_en=1 -> spi_data=16'hBFFC, ack_b only.
REQ-023 Contention: req_a=req_b=1 continuously after reset -> grants A,B,A,B; spi_done-to-next-spi_start spacing = 7 cycles; no ack overlap.
REQ-024 SYNC_UPDATE=1: write A then B -> ldac_n=1 after A completes; ldac_n=0 for one cycle on the first GAP cycle after B's spi_done; a following write to A alone gives no pulse.
REQ-025 Robustness: spi_done pulsed in IDLE -> no state change; rst asserted mid-WAIT -> GAP, spi_start=0, no ack; stray spi_done after reset ignored.
